// File: rtl/bcd_countdown_timer.sv
// BCD countdown timer: loadable multi-digit down-counter with run/pause control,
// one-shot or auto-reload expiry and a single-cycle done pulse.
module bcd_countdown_timer #(
  parameter int DIGITS      = 2,
  parameter int AUTO_RELOAD = 0
) (
  input  logic                  slowclk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  pause,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  paused,
  output logic                  done,
  output logic [1:0]            state_o
);

  localparam int W = 4 * DIGITS;

  // state_o encoding: 0 IDLE, 1 RUN, 2 PAUSED, 3 EXPIRED
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  state_t         state_q;
  logic [W-1:0]   count_q;
  logic [W-1:0]   reload_q;
  logic           done_q;

  logic [W-1:0]   load_sat;
  logic [W-1:0]   count_dec;
  logic           borrow;
  logic           count_zero;
  logic           count_one;

  // Out-of-range digits clamp to 9 so the counter never holds a non-BCD nibble.
  always_comb begin
    load_sat = '0;
    for (int i = 0; i < DIGITS; i++) begin
      load_sat[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end
  end

  // Borrow ripples through every digit within one cycle.
  always_comb begin
    count_dec = '0;
    borrow    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          count_dec[4*i +: 4] = 4'd9;
        end else begin
          count_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow              = 1'b0;
        end
      end else begin
        count_dec[4*i +: 4] = count_q[4*i +: 4];
      end
    end
  end

  assign count_zero = (count_q == '0);
  assign count_one  = (count_q == W'(1));

  always_ff @(posedge slowclk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        count_q  <= load_sat;
        reload_q <= load_sat;
        state_q  <= ST_IDLE;
      end else if (pause) begin
        if (state_q == ST_RUN) begin
          state_q <= ST_PAUSED;
        end
      end else if (start && (state_q == ST_IDLE || state_q == ST_PAUSED)) begin
        if (!count_zero) begin
          state_q <= ST_RUN;
        end
      end else if (tick && state_q == ST_RUN) begin
        if (count_one) begin
          done_q <= 1'b1;
          if (AUTO_RELOAD != 0) begin
            count_q <= reload_q;
          end else begin
            count_q <= '0;
            state_q <= ST_EXPIRED;
          end
        end else if (!count_zero) begin
          count_q <= count_dec;
        end
      end
    end
  end

  assign count   = count_q;
  assign done    = done_q;
  assign running = (state_q == ST_RUN);
  assign paused  = (state_q == ST_PAUSED);
  assign state_o = state_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: three configurations driven in parallel and
// checked every cycle against a decimal-arithmetic model, plus literal pins.
module tb_bcd_countdown_timer;

  logic        slowclk;
  logic        rst, tick, load, start, pause;
  logic [31:0] lv;

  logic [7:0]  c0;  logic [11:0] c1;  logic [7:0] c2;
  logic        run0, run1, run2, pau0, pau1, pau2, dn0, dn1, dn2;
  logic [1:0]  st0, st1, st2;

  bcd_countdown_timer #(.DIGITS(2), .AUTO_RELOAD(0)) u0 (
    .slowclk(slowclk), .rst(rst), .tick(tick), .load(load), .load_val(lv[7:0]),
    .start(start), .pause(pause), .count(c0), .running(run0), .paused(pau0),
    .done(dn0), .state_o(st0));
  bcd_countdown_timer #(.DIGITS(3), .AUTO_RELOAD(0)) u1 (
    .slowclk(slowclk), .rst(rst), .tick(tick), .load(load), .load_val(lv[11:0]),
    .start(start), .pause(pause), .count(c1), .running(run1), .paused(pau1),
    .done(dn1), .state_o(st1));
  bcd_countdown_timer #(.DIGITS(2), .AUTO_RELOAD(1)) u2 (
    .slowclk(slowclk), .rst(rst), .tick(tick), .load(load), .load_val(lv[7:0]),
    .start(start), .pause(pause), .count(c2), .running(run2), .paused(pau2),
    .done(dn2), .state_o(st2));

  // clock / reset
  initial slowclk = 1'b0;
  always #5 slowclk = ~slowclk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXPIRED = 3;
  int m_val  [3];
  int m_rel  [3];
  int m_st   [3];
  bit m_done [3];

  logic [7:0] d31 [12] = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                           8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
  logic [7:0] d34 [7]  = '{8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h03, 8'h02};

  function automatic int dg(input int k);
    return (k == 1) ? 3 : 2;
  endfunction

  function automatic bit ar(input int k);
    return (k == 2);
  endfunction

  function automatic int sat_val(input logic [31:0] v, input int d);
    int acc = 0;
    int pw  = 1;
    int nib;
    for (int i = 0; i < d; i++) begin
      nib = int'(v[4*i +: 4]);
      if (nib > 9) nib = 9;
      acc += nib * pw;
      pw  *= 10;
    end
    return acc;
  endfunction

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r = '0;
    int x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // reference model: count kept as a plain decimal integer
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      m_done[k] = 1'b0;
      if (rst) begin
        m_val[k] = 0; m_rel[k] = 0; m_st[k] = M_IDLE;
      end else if (load) begin
        m_val[k] = sat_val(lv, dg(k)); m_rel[k] = m_val[k]; m_st[k] = M_IDLE;
      end else if (pause) begin
        if (m_st[k] == M_RUN) m_st[k] = M_PAUSED;
      end else if (start && (m_st[k] == M_IDLE || m_st[k] == M_PAUSED)) begin
        if (m_val[k] != 0) m_st[k] = M_RUN;
      end else if (tick && m_st[k] == M_RUN && m_val[k] > 0) begin
        m_val[k] = m_val[k] - 1;
        if (m_val[k] == 0) begin
          m_done[k] = 1'b1;
          if (ar(k)) m_val[k] = m_rel[k];
          else       m_st[k]  = M_EXPIRED;
        end
      end
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // driver: inputs are stable across the edge, model advances with the DUT
  task automatic cyc();
    @(posedge slowclk);
    model_step();
    #2;
  endtask

  task automatic set_in(input bit r, input bit l, input bit s, input bit p, input bit t);
    rst = r; load = l; start = s; pause = p; tick = t;
  endtask

  // scoreboard compare against the model every cycle
  always @(negedge slowclk) begin
    if (chk_en) begin
      logic [31:0] ac [3];
      logic [2:0]  ar_run, ar_pau, ar_dn;
      logic [1:0]  ast [3];
      ac[0] = {24'b0, c0}; ac[1] = {20'b0, c1}; ac[2] = {24'b0, c2};
      ar_run = {run2, run1, run0};
      ar_pau = {pau2, pau1, pau0};
      ar_dn  = {dn2, dn1, dn0};
      ast[0] = st0; ast[1] = st1; ast[2] = st2;
      for (int k = 0; k < 3; k++) begin
        check($sformatf("u%0d_count", k), ac[k], to_bcd(m_val[k]));
        check($sformatf("u%0d_running", k), {31'b0, ar_run[k]}, {31'b0, m_st[k] == M_RUN});
        check($sformatf("u%0d_paused", k), {31'b0, ar_pau[k]}, {31'b0, m_st[k] == M_PAUSED});
        check($sformatf("u%0d_done", k), {31'b0, ar_dn[k]}, {31'b0, m_done[k]});
        check($sformatf("u%0d_state", k), {30'b0, ast[k]}, 32'(m_st[k]));
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_val[k] = 0; m_rel[k] = 0; m_st[k] = M_IDLE; m_done[k] = 1'b0;
    end
    lv = '0;
    set_in(1, 0, 0, 0, 0);
    cyc(); cyc();
    chk_en = 1'b1;
    check("reset_count", {24'b0, c0}, 32'h0);
    check("reset_outs", {29'b0, run0, pau0, dn0}, 32'h0);

    // count down 12 -> 00, one-shot expiry
    lv = 32'h12; set_in(0, 1, 0, 0, 0); cyc();
    set_in(0, 0, 1, 0, 0); cyc();
    set_in(0, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) begin
      cyc();
      check("r031_count", {24'b0, c0}, {24'b0, d31[i]});
      check("r031_done", {31'b0, dn0}, {31'b0, i == 11});
    end
    check("r031_running", {31'b0, run0}, 32'h0);
    check("r031_state", {30'b0, st0}, 32'd3);
    cyc();
    check("r031_hold", {23'b0, dn0, c0}, 32'h0);

    // full-width borrow and digit clamping on 3 digits
    lv = 32'h100; set_in(0, 1, 0, 0, 0); cyc();
    set_in(0, 0, 1, 0, 0); cyc();
    set_in(0, 0, 0, 0, 1); cyc();
    check("r032_borrow", {20'b0, c1}, 32'h099);
    lv = 32'h0F5; set_in(0, 1, 0, 0, 0); cyc();
    check("r032_clamp3", {20'b0, c1}, 32'h095);
    check("r032_clamp2", {24'b0, c0}, 32'h95);

    // pause wins over tick, resume, then expire
    lv = 32'h05; set_in(0, 1, 0, 0, 0); cyc();
    set_in(0, 0, 1, 0, 0); cyc();
    set_in(0, 0, 0, 0, 1); cyc(); cyc();
    set_in(0, 0, 0, 1, 1); cyc();
    check("r033_pause_cnt", {24'b0, c0}, 32'h03);
    check("r033_paused", {31'b0, pau0}, 32'h1);
    set_in(0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) cyc();
    check("r033_held", {24'b0, c0}, 32'h03);
    set_in(0, 0, 1, 0, 0); cyc();
    check("r033_resume", {31'b0, run0}, 32'h1);
    set_in(0, 0, 0, 0, 1); cyc(); cyc(); cyc();
    check("r033_end", {23'b0, dn0, c0}, 32'h100);

    // auto-reload sequence on the reload instance
    lv = 32'h03; set_in(0, 1, 0, 0, 0); cyc();
    set_in(0, 0, 1, 0, 0); cyc();
    set_in(0, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) begin
      cyc();
      check("r034_count", {24'b0, c2}, {24'b0, d34[i]});
      check("r034_done", {31'b0, dn2}, {31'b0, i == 2 || i == 5});
      check("r034_running", {31'b0, run2}, 32'h1);
    end

    // zero start ignored, reset mid-run, start+pause from IDLE
    lv = 32'h00; set_in(0, 1, 0, 0, 0); cyc();
    set_in(0, 0, 1, 0, 0); cyc();
    check("r035_zero_start", {30'b0, run0, dn0}, 32'h0);
    lv = 32'h40; set_in(0, 1, 0, 0, 0); cyc();
    set_in(0, 0, 1, 0, 0); cyc();
    set_in(0, 0, 0, 0, 1); cyc();
    check("r035_pre_rst", {24'b0, c0}, 32'h39);
    set_in(1, 0, 1, 0, 1); cyc();
    check("r035_rst", {21'b0, run0, pau0, dn0, c0}, 32'h0);
    set_in(0, 1, 0, 0, 0); cyc();
    set_in(0, 0, 1, 1, 0); cyc();
    check("r035_start_pause", {30'b0, run0, pau0}, 32'h0);

    // randomized traffic, model-checked every cycle
    for (int n = 0; n < 3000; n++) begin
      lv = $urandom();
      set_in($urandom_range(63) == 0, $urandom_range(15) == 0, $urandom_range(5) == 0,
             $urandom_range(9) == 0, $urandom_range(1) == 0);
      cyc();
    end
    set_in(0, 0, 0, 0, 0);
    cyc();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
